// File: rtl/elevator_emergency_pkg.sv
// -----------------------------------------------------------------------------
// elevator_emergency_pkg
//   Shared definitions for the cabin SOS button encoder.
//   - sos_enc_state_t : encoder FSM state encoding (also exported on the
//                       encoder's fsm_state debug port)
//   - SOS_*_DEF       : default timing parameters for the encoder
//   - cnt_width()     : width of a saturating counter that must hold 0..param
// -----------------------------------------------------------------------------
package elevator_emergency_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,   // no emergency; a debounced press raises one
      S_ACTIVE = 2'd1,   // emergency active; waiting for a cancel press
      S_HOLD   = 2'd2,   // cancel press in progress, counting hold time
      S_LOCK   = 2'd3    // toggle issued; waiting for handler and release
   } sos_enc_state_t;

   localparam int SOS_DEBOUNCE_DEF = 4;
   localparam int SOS_HOLD_DEF     = 8;
   localparam int SOS_LOCKOUT_DEF  = 6;

   // Counter width able to represent every value from 0 up to param.
   function automatic int cnt_width(input int param);
      return $clog2(param + 1);
   endfunction

endpackage

// File: rtl/sos_debouncer.sv
// -----------------------------------------------------------------------------
// sos_debouncer
//   Two-flop synchroniser followed by a level debouncer. The debounced level
//   only moves to the synchronised level after that level has differed from
//   it for DEBOUNCE_CYCLES consecutive edges; any return to the old level
//   restarts the count.
//
//   Ports
//     clk      in   rising-edge clock
//     rst_n    in   asynchronous active-low reset
//     btn_raw  in   raw asynchronous button, active high
//     deb      out  debounced, registered button level
// -----------------------------------------------------------------------------
module sos_debouncer
   import elevator_emergency_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = SOS_DEBOUNCE_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic deb
);

   localparam int DW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);

   logic          meta;
   logic          sync;
   logic [DW-1:0] dcnt;

   // Synchroniser: the first flop may go metastable, only sync is used.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         sync <= 1'b0;
      end else begin
         meta <= btn_raw;
         sync <= meta;
      end
   end

   // Debounce counter. It never exceeds D_LAST: reaching it commits the new
   // level and clears the count in the same edge, so it cannot wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb  <= 1'b0;
         dcnt <= '0;
      end else if (sync == deb) begin
         dcnt <= '0;
      end else if (dcnt >= D_LAST) begin
         deb  <= sync;
         dcnt <= '0;
      end else begin
         dcnt <= dcnt + 1'b1;
      end
   end

endmodule

// File: rtl/sos_button_encoder.sv
// -----------------------------------------------------------------------------
// sos_button_encoder
//   Turns the cabin SOS push-button into single toggles of sos_flip for the
//   sos_handler. A short debounced press raises an emergency; cancelling an
//   active emergency needs the button held for HOLD_CYCLES. After each toggle
//   the encoder locks out further presses for LOCKOUT_CYCLES and checks that
//   sos_mode followed; if it has not by then, sos_fault latches until reset.
//
//   Ports
//     clk          in   rising-edge clock
//     rst_n        in   asynchronous active-low reset
//     sos_btn_raw  in   raw bouncing button, active high
//     sos_mode     in   mode fed back from sos_handler
//     sos_flip     out  toggle line to sos_handler (registered)
//     sos_pending  out  in lockout and sos_mode not yet at expected value
//     sos_fault    out  sticky: handler missed the lockout window
//     fsm_state    out  current encoder state (sos_enc_state_t encoding)
// -----------------------------------------------------------------------------
module sos_button_encoder
   import elevator_emergency_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = SOS_DEBOUNCE_DEF,
   parameter int HOLD_CYCLES     = SOS_HOLD_DEF,
   parameter int LOCKOUT_CYCLES  = SOS_LOCKOUT_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sos_btn_raw,
   input  logic       sos_mode,
   output logic       sos_flip,
   output logic       sos_pending,
   output logic       sos_fault,
   output logic [1:0] fsm_state
);

   localparam int HW = cnt_width(HOLD_CYCLES);
   localparam int LW = cnt_width(LOCKOUT_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);

   logic           deb;
   sos_enc_state_t state, state_n;
   logic [HW-1:0]  hcnt, hcnt_n;
   logic [LW-1:0]  lcnt, lcnt_n;
   logic           exp_mode, exp_mode_n;
   logic           flip_n;
   logic           pending_n;
   logic           fault_n;

   sos_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (sos_btn_raw),
      .deb     (deb)
   );

   always_comb begin
      state_n    = state;
      hcnt_n     = hcnt;
      lcnt_n     = lcnt;
      exp_mode_n = exp_mode;
      flip_n     = sos_flip;

      case (state)
         S_IDLE: begin
            if (sos_mode) begin
               // Handler was activated by some other source.
               state_n = S_ACTIVE;
            end else if (deb) begin
               flip_n     = ~sos_flip;
               exp_mode_n = 1'b1;
               lcnt_n     = '0;
               state_n    = S_LOCK;
            end
         end

         S_ACTIVE: begin
            if (!sos_mode) begin
               state_n = S_IDLE;
            end else if (deb) begin
               hcnt_n  = HW'(1);
               state_n = S_HOLD;
            end
         end

         S_HOLD: begin
            // A sos_mode fall wins over a completing hold: no toggle then.
            if (!sos_mode) begin
               hcnt_n  = '0;
               state_n = S_IDLE;
            end else if (!deb) begin
               hcnt_n  = '0;
               state_n = S_ACTIVE;
            end else if (hcnt >= HOLD_LAST) begin
               flip_n     = ~sos_flip;
               exp_mode_n = 1'b0;
               hcnt_n     = '0;
               lcnt_n     = '0;
               state_n    = S_LOCK;
            end else begin
               hcnt_n = hcnt + 1'b1;
            end
         end

         S_LOCK: begin
            // Leaving needs the window elapsed, the button released (so a held
            // button never re-triggers) and the handler in agreement.
            if ((lcnt >= LOCK_LAST) && !deb && (sos_mode == exp_mode)) begin
               lcnt_n  = '0;
               state_n = exp_mode ? S_ACTIVE : S_IDLE;
            end else if (lcnt < LOCK_LAST) begin
               lcnt_n = lcnt + 1'b1;
            end
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase

      // Registered view of "in lockout and handler not there yet", so it rises
      // on the same edge as the toggle while sos_mode still has its old value.
      pending_n = (state_n == S_LOCK) && (sos_mode != exp_mode_n);

      fault_n = sos_fault |
                ((state == S_LOCK) && (lcnt == LOCK_LAST) && (sos_mode != exp_mode));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         hcnt        <= '0;
         lcnt        <= '0;
         exp_mode    <= 1'b0;
         sos_flip    <= 1'b0;
         sos_pending <= 1'b0;
         sos_fault   <= 1'b0;
      end else begin
         state       <= state_n;
         hcnt        <= hcnt_n;
         lcnt        <= lcnt_n;
         exp_mode    <= exp_mode_n;
         sos_flip    <= flip_n;
         sos_pending <= pending_n;
         sos_fault   <= fault_n;
      end
   end

   assign fsm_state = state;

endmodule

// File: doc/sos_button_encoder.md
# sos_button_encoder

Drives the `sos_flip` toggle line consumed by `sos_handler` from the cabin's physical SOS push-button. It synchronises and debounces the raw button and issues exactly one `sos_flip` toggle per accepted request. A short press raises an emergency, and a long press is required to cancel it. It then monitors `sos_mode` to confirm that the handler followed, and flags a fault if it does not.

## Interface
- `DEBOUNCE_CYCLES`, 4: cycles the synchronised button must hold a new level before it is accepted (≥1).
- `HOLD_CYCLES`, 8: debounced-high cycles required to cancel an active emergency (≥1).
- `LOCKOUT_CYCLES`, 6: cycles after a toggle during which presses are ignored and the handler must acknowledge (≥1).
- `clk`  input  1  single clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `sos_btn_raw`  input  1  raw, asynchronous, bouncing button, active high.
- `sos_mode`  input  1  mode fed back from `sos_handler`.
- `sos_flip`  output  1  toggle line to `sos_handler`; each accepted request inverts it.
- `sos_pending`  output  1  a toggle has been issued and `sos_mode` does not yet equal the expected value.
- `sos_fault`  output  1  sticky; the handler failed to acknowledge within `LOCKOUT_CYCLES`.

## Operation
- **Input path:** a 2-flop synchroniser produces `sync`.
- **Debounce:**
  - Counter `dcnt` is cleared whenever `sync == deb`.
  - On each edge where `sync != deb`: if `dcnt == DEBOUNCE_CYCLES-1`, then `deb <= sync` and `dcnt <= 0`; otherwise `dcnt++`.
  - A single-cycle glitch back to the old level clears `dcnt`.
- **Internal state:** register `exp_mode` holds the value `sos_mode` must reach.
- **FSM states:** `S_IDLE`, `S_ACTIVE`, `S_HOLD`, `S_LOCK`.
  - **S_IDLE:**
    - `deb==1` and `sos_mode==0`: toggle `sos_flip`, set `exp_mode=1`, go to `S_LOCK`.
    - `sos_mode==1` (handler activated elsewhere): go to `S_ACTIVE`, no toggle.
  - **S_ACTIVE:**
    - `sos_mode==0`: go to `S_IDLE`.
    - else `deb==1`: go to `S_HOLD` with `hcnt=1`.
  - **S_HOLD:**
    - `sos_mode==0`: go to `S_IDLE`.
    - `deb==0`: go to `S_ACTIVE`; the short press is ignored.
    - `hcnt==HOLD_CYCLES-1` with `deb==1`: toggle `sos_flip`, set `exp_mode=0`, go to `S_LOCK`.
    - else `hcnt++`.
  - **S_LOCK:**
    - `lcnt` counts up from 0.
    - Exit when `lcnt ≥ LOCKOUT_CYCLES-1`, `deb==0` and `sos_mode==exp_mode`. The next state is `S_ACTIVE` if `exp_mode` is 1, else `S_IDLE`.
    - Holding the button through lockout keeps the FSM in `S_LOCK`. It never re-triggers without a release.
- **`sos_pending`:** high iff state is `S_LOCK` and `sos_mode != exp_mode`.
- **`sos_fault`:**
  - Set when `lcnt == LOCKOUT_CYCLES-1` and `sos_mode != exp_mode`.
  - Cleared only by reset.
  - The FSM stays in `S_LOCK` until the mismatch resolves.
- **Counter widths:** each counter is `$clog2(param+1)` bits and saturates; none wraps.

## Timing
- **Reset values:** all outputs and registers are 0 while `rst_n==0`, asserted asynchronously. This includes `sos_flip=0`, `sos_pending=0`, `sos_fault=0`, state `S_IDLE`, `deb=0`, `exp_mode=0` and all counters.
- **Press-to-toggle latency:** for a clean press, `sos_flip` toggles on the (`DEBOUNCE_CYCLES`+3)-th rising edge, counting the first edge that samples `sos_btn_raw` high as edge 1.
- **Cancel latency:** `deb` rising, then `HOLD_CYCLES` further edges to the toggle.
- **Registered outputs:** `sos_flip` is a registered output. `sos_pending` is registered, and it asserts on the same edge as the toggle when `sos_mode` has not yet changed.
- **Simultaneous events:** in `S_HOLD`, a `sos_mode` fall and `deb` reaching the hold count on the same cycle resolve to `S_IDLE`, with no toggle.
- **Reset mid-operation:** any state, including mid-debounce, `S_HOLD` or `S_LOCK`, returns immediately to the reset values. The press in progress is discarded.

## Structure
- Package `elevator_emergency_pkg` holds:
  - the state enum `sos_enc_state_t`;
  - the default parameter constants `SOS_DEBOUNCE_DEF`, `SOS_HOLD_DEF` and `SOS_LOCKOUT_DEF`.
- Sub-module `sos_debouncer` (synchroniser plus debounce counter, parameter `DEBOUNCE_CYCLES`, output `deb`) is instantiated once.
- The FSM, hold/lock counters and fault logic sit in the top module.

## Test plan
All scenarios use the defaults (4/8/6). The bench pairs the encoder with a behavioural handler that inverts `sos_mode` one cycle after each `sos_flip` change, unless stated otherwise.
- **Reset:** `rst_n=0` with the button high → `sos_flip=0`, `sos_pending=0`, `sos_fault=0`; no toggle on release of reset until debounce completes.
- **Clean press:** raw high for 20 cycles → `sos_flip` goes 0→1 on edge 7; `sos_pending` is high for 1 cycle; `sos_mode=1`; then exactly one toggle in total.
- **Bounce rejection:** raw pulses of 3 high / 2 low repeated 5 times → `sos_flip` stays 0 and `deb` never rises.
- **Cancel:** with `sos_mode=1`, a 5-cycle debounced press → no toggle. A 12-cycle debounced press → `sos_flip` goes 1→0 8 edges after `deb` rises, and `sos_mode` goes to 0.
- **Handler stuck:** `sos_mode` is forced to 0, then a press → `sos_pending` stays high and `sos_fault` sets 6 cycles after the toggle. `sos_fault` persists after `sos_mode` is released, until reset.
- **Reset mid-hold:** `rst_n` pulsed low for 1 cycle during `S_HOLD` at `hcnt=5` → outputs are 0 immediately; state `S_IDLE`; no toggle.
